// File: rtl/psram_rd_capture.sv
// PSRAM read-burst capture: DDR word strobes from RWDS into a small output FIFO.
// Each captured word is visible one cycle after its strobe; a word that meets a full FIFO with no pop is dropped and flagged.
module psram_rd_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  burst_len,
  input  logic [7:0]  dq_rise,
  input  logic [7:0]  dq_fall,
  input  logic        rwds_rise,
  input  logic        rwds_fall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DS, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [16:0]     mem_q [FIFO_DEPTH];

  logic strobe, push, push_last, pop, full, wr_en;

  assign strobe = rwds_rise && !rwds_fall;
  assign full   = (cnt_q == (PW+1)'(FIFO_DEPTH));

  assign rd_valid     = (cnt_q != '0);
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  assign rd_last      = rd_valid ? mem_q[rd_ptr_q][16] : 1'b0;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    err_to_d  = err_to_q;
    err_ov_d  = err_ov_q;
    push      = 1'b0;
    push_last = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = (burst_len == 5'd0) ? 5'd16 : burst_len;
          idx_d    = 5'd0;
          tmo_d    = '0;
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
          state_d  = WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (strobe) begin
          push      = 1'b1;
          push_last = (len_q == 5'd1);
          idx_d     = 5'd1;
          state_d   = push_last ? IDLE : CAPTURE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CAPTURE: begin
        // No timeout here: the device may pause RWDS between words.
        if (strobe) begin
          push      = 1'b1;
          push_last = (idx_q == len_q - 5'd1);
          idx_d     = idx_q + 5'd1;
          if (push_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    pop   = rd_valid && rd_ready;
    wr_en = push && (!full || pop);
    if (push && !wr_en) err_ov_d = 1'b1;

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= 5'd0;
      idx_q    <= 5'd0;
      tmo_q    <= '0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked by rd_valid.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= {push_last, dq_rise, dq_fall};
  end

endmodule

// File: tb/tb_psram_rd_capture.sv
// Randomized scoreboard bench for psram_rd_capture against a queue-level burst model.
module tb_psram_rd_capture;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  burst_len = 5'd0;
  logic [7:0]  dq_rise = 8'h00, dq_fall = 8'h00;
  logic        rwds_rise = 1'b0, rwds_fall = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_last, busy, err_timeout, err_overflow;
  logic        rd_ready = 1'b0;

  psram_rd_capture #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .rwds_rise(rwds_rise), .rwds_fall(rwds_fall),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding words as a queue, burst progress as counts.
  logic [16:0] exp_q[$];
  int  occ = 0;
  bit  m_busy = 0, m_to = 0, m_ovf = 0;
  int  m_rem = 0, m_got = 0, m_wait = 0;
  bit  chk_en = 0;
  bit  exp_vld = 0, exp_busy = 0, exp_to = 0, exp_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("err_timeout", 32'(err_timeout), 32'(exp_to));
      chk("err_overflow", 32'(err_overflow), 32'(exp_ovf));
      if (exp_vld && exp_q.size() > 0) begin
        chk("rd_data", 32'(rd_data), 32'(exp_q[0][15:0]));
        chk("rd_last", 32'(rd_last), 32'(exp_q[0][16]));
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic st, input logic [4:0] bl, input logic rr, input logic rf,
                      input logic [7:0] dr, input logic [7:0] df, input logic rdy);
    bit pop, n_busy, n_to, n_ovf, last;
    @(posedge clk); #1;
    reset = 1'b0; start = st; burst_len = bl;
    rwds_rise = rr; rwds_fall = rf; dq_rise = dr; dq_fall = df; rd_ready = rdy;
    exp_vld = (occ > 0); exp_busy = m_busy; exp_to = m_to; exp_ovf = m_ovf; chk_en = 1;
    pop = rdy && (occ > 0);
    n_busy = m_busy; n_to = m_to; n_ovf = m_ovf;
    if (!m_busy) begin
      if (st) begin
        n_busy = 1; m_rem = (bl == 5'd0) ? 16 : int'(bl);
        m_got = 0; m_wait = 0; n_to = 0; n_ovf = 0;
      end
    end else if (rr && !rf) begin
      m_got++;
      last = (m_got == m_rem);
      if (occ < DEPTH || pop) begin
        exp_q.push_back({last, dr, df});
        occ++;
      end else n_ovf = 1;
      if (last) n_busy = 0;
    end else if (m_got == 0) begin
      if (m_wait == TMO - 1) begin n_to = 1; n_busy = 0; end
      else m_wait++;
    end
    if (pop) occ--;
    m_busy = n_busy; m_to = n_to; m_ovf = n_ovf;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, rdy);
  endtask

  task automatic strobe(input logic [7:0] dr, input logic [7:0] df, input logic rdy);
    step(1'b0, 5'd0, 1'b1, 1'b0, dr, df, rdy);
  endtask

  task automatic do_reset(input logic st);
    @(posedge clk); #1;
    reset = 1'b1; start = st; burst_len = 5'd3; rd_ready = 1'b0;
    rwds_rise = 1'b1; rwds_fall = 1'b0;
    chk_en = 0;
    exp_q.delete(); occ = 0; m_busy = 0; m_to = 0; m_ovf = 0;
  endtask

  logic [7:0] rb [4];
  logic [7:0] fb [4];
  logic [1:0] pat [7];

  initial begin
    rb[0] = 8'h11; rb[1] = 8'h33; rb[2] = 8'h55; rb[3] = 8'h77;
    fb[0] = 8'h22; fb[1] = 8'h44; fb[2] = 8'h66; fb[3] = 8'h88;
    pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;
    pat[4] = 2'b01; pat[5] = 2'b11; pat[6] = 2'b10;

    do_reset(1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("reset rd_data", 32'(rd_data), 32'h0);
    chk("reset rd_last", 32'(rd_last), 32'h0);

    // Basic four-word burst with a gap cycle after the second word.
    step(1'b1, 5'd4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      strobe(rb[i], fb[i], 1'b1);
      if (i == 1) idle(1, 1'b1);
    end
    idle(3, 1'b1);

    // Timeout, then a new start clears the flag.
    step(1'b1, 5'd2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle(TMO + 6, 1'b1);
    step(1'b1, 5'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    strobe(8'hA5, 8'h5A, 1'b1);
    idle(3, 1'b1);

    // Overflow: six words into a four-entry FIFO with no consumer.
    step(1'b1, 5'd6, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) strobe(8'(i + 1), 8'(8'hF0 + i), 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Only rise=1/fall=0 cycles are strobes.
    step(1'b1, 5'd2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++)
      step(1'b0, 5'd0, pat[i][1], pat[i][0], 8'(8'hC0 + i), 8'(8'h30 + i), 1'b1);
    idle(3, 1'b1);

    // Reset mid-burst with a start in the reset cycle; later strobes ignored.
    step(1'b1, 5'd8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    strobe(8'hD1, 8'hE1, 1'b0);
    strobe(8'hD2, 8'hE2, 1'b0);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) strobe(8'(i), 8'(i), 1'b1);
    idle(2, 1'b1);

    // Full FIFO with simultaneous push and pop across pointer wrap.
    step(1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) strobe(8'(8'h40 + i), 8'(i), 1'b0);
    for (int i = 4; i < 16; i++) strobe(8'(8'h40 + i), 8'(i), 1'b1);
    idle(6, 1'b1);

    // Randomized bursts.
    for (int b = 0; b < 40; b++) begin
      step(1'b1, 5'($urandom_range(0, 16)), 1'b0, 1'b0, 8'h00, 8'h00, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 200 && m_busy; c++) begin
        logic [1:0] rw;
        rw = ($urandom_range(0, 9) < 5) ? 2'b10 : 2'($urandom);
        step(1'($urandom_range(0, 19) == 0), 5'($urandom), rw[1], rw[0],
             8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
      end
      if ($urandom_range(0, 9) == 0) do_reset(1'($urandom));
      idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle(10, 1'b1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/psram_rd_capture.md
PSRAM_RD_CAPTURE -- requirements
Module: psram_rd_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set output FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 64, SHALL set clk cycles allowed from start to first valid word.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse: begin a read burst capture.
REQ-006 burst_len  in  5  words to capture, 1..16; sampled on start; 0 treated as 16.
REQ-007 dq_rise  in  8  DQ byte sampled on rising DQS edge, from input DDR register, clk-aligned.
REQ-008 dq_fall  in  8  DQ byte sampled on falling DQS edge, same cycle as dq_rise.
REQ-009 rwds_rise  in  1  RWDS sampled on rising half.
REQ-010 rwds_fall  in  1  RWDS sampled on falling half.
REQ-011 rd_data  out  16  captured word, FIFO head.
REQ-012 rd_valid  out  1  FIFO non-empty.
REQ-013 rd_last  out  1  head word is final word of burst.
REQ-014 rd_ready  in  1  consumer accepts head when rd_valid & rd_ready.
REQ-015 busy  out  1  capture in progress.
REQ-016 err_timeout  out  1  sticky: no word arrived within TIMEOUT.
REQ-017 err_overflow  out  1  sticky: word arrived with FIFO full.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_DS, CAPTURE; busy = (state != IDLE).
REQ-019 IDLE: start SHALL latch burst_len, clear both error flags, clear timeout counter, go WAIT_DS next cycle; start outside IDLE SHALL be ignored.
REQ-020 Word strobe SHALL be cycle with rwds_rise=1 and rwds_fall=0; word = {dq_rise, dq_fall} (rise byte in [15:8]).
REQ-021 Strobe outside WAIT_DS/CAPTURE SHALL be ignored.
REQ-022 WAIT_DS: counter increments each cycle; first strobe SHALL capture word 0, enter CAPTURE (or IDLE if burst_len=1).
REQ-023 WAIT_DS: counter reaching TIMEOUT-1 without strobe SHALL set err_timeout and return IDLE, no word pushed.
REQ-024 CAPTURE: each strobe captures next word; non-strobe cycles SHALL wait without timeout.
REQ-025 Capture of word burst_len-1 SHALL tag it last and return IDLE same edge.
REQ-026 Captured word SHALL appear on rd_data/rd_valid exactly one cycle after its strobe cycle when FIFO empty.
REQ-027 FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH; simultaneous push and pop SHALL keep count unchanged and succeed even when full.
REQ-028 Push with FIFO full and no same-cycle pop SHALL drop the word, set err_overflow, still count toward burst_len.
REQ-029 Dropped last word SHALL leave no rd_last; FSM still returns IDLE.
REQ-030 Pop with FIFO empty SHALL have no effect.
REQ-031 rd_data/rd_last SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-032 Error flags SHALL persist until reset or next accepted start.
REQ-033 FIFO contents from prior burst SHALL remain readable after new start.

Reset
REQ-034 reset SHALL force IDLE, empty FIFO, pointers/counters 0.
REQ-035 Outputs after reset: rd_valid=0, rd_last=0, rd_data=0, busy=0, err_timeout=0, err_overflow=0.
REQ-036 reset mid-burst SHALL discard partial burst and all FIFO contents; start in same cycle as reset ignored.

Verification
REQ-037 start, burst_len=4, rd_ready=1, strobes with (rise,fall) bytes (11,22),(33,44),(55,66),(77,88) -> words 0x1122,0x3344,0x5566,0x7788 one cycle after each strobe, rd_last only on 0x7788, busy low after 4th strobe.
REQ-038 start, no strobe for 64 cycles -> err_timeout=1 at cycle 64, busy=0, rd_valid=0; new start clears err_timeout.
REQ-039 FIFO_DEPTH=4, burst_len=6, rd_ready=0 -> 4 words stored, words 5-6 dropped, err_overflow=1, no rd_last visible; then rd_ready=1 drains exactly 4 words.
REQ-040 Strobe pattern rise=1,fall=1 and rise=0,fall=1 interleaved -> no words captured; only rise=1,fall=0 cycles count.
REQ-041 reset asserted after 2 of 8 words -> next cycle rd_valid=0, busy=0; following strobes ignored.
REQ-042 FIFO full, rd_ready=1 with strobe same cycle -> no overflow, count stays 4, order preserved across pointer wrap.
